// File: rtl/hog_pkg.sv
// Shared definitions for the HOG histogram accumulator.
//   state_t    : controller state encoding
//   *_W_DEF    : default accumulator / bin-index / magnitude widths
//   sat_add()  : unsigned saturating add, clipped to a given result width
package hog_pkg;

    localparam int BIN_W_DEF  = 12;
    localparam int ADDR_W_DEF = 5;
    localparam int MAG_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_ACCUM      = 2'd1,
        ST_FLUSH_WAIT = 2'd2,
        ST_DRAIN      = 2'd3
    } state_t;

    // Both operands are already below 2**width, so the sum fits in width+1
    // bits; any bit at or above position 'width' is the adder's carry-out,
    // and a carry clips the result to all-ones of 'width' bits.
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] mag,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [31:0] max_val;
        sum     = {1'b0, acc} + {1'b0, mag};
        max_val = 32'((33'd1 << width) - 33'd1);
        return (|(sum >> width)) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/hist_accum_ctrl_if.sv
// Sample-in / drained-bin-out bundle of the histogram accumulator.
//   i_valid/i_bin/i_mag : gradient sample stream (one per cycle)
//   i_flush             : drain + clear request
//   o_busy/o_drop       : not accepting samples / sample discarded
//   o_valid/o_idx/o_data/o_done : drained bin stream, o_done on the last bin
// master = upstream producer / downstream consumer side, slave = controller.
interface hist_accum_ctrl_if import hog_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BIN_W  = BIN_W_DEF,
    parameter int MAG_W  = MAG_W_DEF
);
    logic              i_valid;
    logic [ADDR_W-1:0] i_bin;
    logic [MAG_W-1:0]  i_mag;
    logic              i_flush;
    logic              o_busy;
    logic              o_drop;
    logic              o_valid;
    logic [ADDR_W-1:0] o_idx;
    logic [BIN_W-1:0]  o_data;
    logic              o_done;

    modport master (
        output i_valid, i_bin, i_mag, i_flush,
        input  o_busy, o_drop, o_valid, o_idx, o_data, o_done
    );

    modport slave (
        input  i_valid, i_bin, i_mag, i_flush,
        output o_busy, o_drop, o_valid, o_idx, o_data, o_done
    );
endinterface

// File: rtl/hist_bin_ram.sv
// Generic bin RAM, no reset on contents.
//   Port A: synchronous write (a_we/a_waddr/a_wdata) plus a registered read
//           (a_raddr -> a_rdata one cycle later).
//   Port B: registered read-only (b_raddr -> b_rdata one cycle later).
// Reads return the value held before a write on the same edge (read-old),
// which the controller relies on both for forwarding and for drain-and-clear.
module hist_bin_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_raddr,
    output logic [DATA_W-1:0] b_rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
        a_rdata <= mem[a_raddr];
        b_rdata <= mem[b_raddr];
    end
endmodule

// File: rtl/hist_accum_ctrl.sv
// Saturating orientation-histogram accumulator built on hist_bin_ram.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sample stream in, drained bins out (hist_accum_ctrl_if.slave)
// After reset every bin is zeroed (INIT), then samples are accumulated with a
// two-stage read-modify-write. A flush waits two cycles for the pipeline to
// retire, then streams every bin out in index order while clearing it.
module hist_accum_ctrl import hog_pkg::*; #(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int MAG_W  = MAG_W_DEF
) (
    input  logic clk,
    input  logic rst,
    hist_accum_ctrl_if.slave bus
);
    localparam int NBINS = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(NBINS - 1);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(NBINS);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic              busy, accept, drain_issue;
    logic              s1_valid_reg;
    logic [ADDR_W-1:0] s1_bin_reg;
    logic [MAG_W-1:0]  s1_mag_reg;
    logic              fwd_valid_reg;
    logic [ADDR_W-1:0] fwd_bin_reg;
    logic [BIN_W-1:0]  fwd_data_reg;
    logic [BIN_W-1:0]  operand, sum;
    logic              drop_reg, valid_reg, done_reg;
    logic [ADDR_W-1:0] idx_reg;

    logic              a_we;
    logic [ADDR_W-1:0] a_waddr;
    logic [BIN_W-1:0]  a_wdata, a_rdata, b_rdata;

    assign busy   = (state_reg != ST_ACCUM);
    assign accept = bus.i_valid && !busy;
    // DRAIN runs one counter step past the last bin so that o_busy stays high
    // while the final bin is still emerging from the RAM read register.
    assign drain_issue = (state_reg == ST_DRAIN) && !cnt_reg[ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_BIN) begin
                    state_next = ST_ACCUM;
                    cnt_next   = '0;
                end
            end
            ST_ACCUM: begin
                if (bus.i_flush) begin
                    state_next = ST_FLUSH_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_FLUSH_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == DRAIN_END) begin
                    state_next = ST_ACCUM;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // The RAM read issued alongside the previous write sees the old value,
    // so a hit on the bin written last cycle takes the forwarded sum instead.
    assign operand = (fwd_valid_reg && (fwd_bin_reg == s1_bin_reg)) ? fwd_data_reg : a_rdata;
    assign sum     = BIN_W'(sat_add(32'(operand), 32'(s1_mag_reg), BIN_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_bin_reg    <= '0;
            s1_mag_reg    <= '0;
            fwd_valid_reg <= 1'b0;
            fwd_bin_reg   <= '0;
            fwd_data_reg  <= '0;
            drop_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            idx_reg       <= '0;
            done_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_bin_reg <= bus.i_bin;
                s1_mag_reg <= bus.i_mag;
            end
            fwd_valid_reg <= s1_valid_reg;
            fwd_bin_reg   <= s1_bin_reg;
            fwd_data_reg  <= sum;
            drop_reg      <= bus.i_valid && busy;
            valid_reg     <= drain_issue;
            done_reg      <= drain_issue && (cnt_reg == LAST_BIN);
            if (drain_issue) begin
                idx_reg <= cnt_reg[ADDR_W-1:0];
            end
        end
    end

    // Port A write: INIT and DRAIN zero the counter address; otherwise the
    // RMW write-back of stage S1.
    always_comb begin
        a_we    = 1'b0;
        a_waddr = s1_bin_reg;
        a_wdata = sum;
        if ((state_reg == ST_INIT) || drain_issue) begin
            a_we    = 1'b1;
            a_waddr = cnt_reg[ADDR_W-1:0];
            a_wdata = '0;
        end else if (s1_valid_reg) begin
            a_we = 1'b1;
        end
    end

    hist_bin_ram #(
        .DATA_W (BIN_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .a_we    (a_we),
        .a_waddr (a_waddr),
        .a_wdata (a_wdata),
        .a_raddr (bus.i_bin),
        .a_rdata (a_rdata),
        .b_raddr (cnt_reg[ADDR_W-1:0]),
        .b_rdata (b_rdata)
    );

    assign bus.o_busy  = busy;
    assign bus.o_drop  = drop_reg;
    assign bus.o_valid = valid_reg;
    assign bus.o_idx   = idx_reg;
    // RAM output register is not reset; gate it so o_data reads 0 off-drain.
    assign bus.o_data  = valid_reg ? b_rdata : '0;
    assign bus.o_done  = done_reg;
endmodule
